// File: rtl/i2s_pkg.sv
// i2s_pkg: frame formats and shared helpers for the TDM/I2S transmitter.
package i2s_pkg;

    typedef enum logic {FMT_I2S, FMT_LJ} fmt_e;

    function automatic int frame_len(int num_ch, int slot_w);
        return num_ch * slot_w;
    endfunction

    function automatic bit params_ok(int sample_w, int slot_w, int num_ch);
        return slot_w >= sample_w && num_ch >= 2 && num_ch % 2 == 0;
    endfunction

endpackage

// File: rtl/i2s_tx_tdm_if.sv
// i2s_tx_tdm_if: valid/ready frame stream into the transmitter.
interface i2s_tx_tdm_if #(parameter int W = 32);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;
    modport master(output data, valid, input ready);
    modport slave(input data, valid, output ready);
endinterface

// File: rtl/i2s_frame_ctr.sv
// i2s_frame_ctr: frame position counter, ws generation and boundary strobe.
module i2s_frame_ctr import i2s_pkg::*; #(
    parameter int SLOT_W = 16,
    parameter int NUM_CH = 2
) (
    input  logic sclk,
    input  logic rst,
    output logic ws,
    output logic last
);
    localparam int F  = frame_len(NUM_CH, SLOT_W);
    localparam int PW = $clog2(F);
    logic [PW-1:0] pos, nxt;
    // last marks the current position as F-1, so the coming edge is a boundary
    assign last = pos == PW'(F - 1);
    assign nxt  = last ? '0 : pos + 1'b1;
    always_ff @(posedge sclk or posedge rst)
        if (rst) begin
            pos <= PW'(F - 1);
            ws  <= 1'b1;
        end else begin
            pos <= nxt;
            ws  <= int'(nxt) / SLOT_W >= NUM_CH / 2;
        end
endmodule

// File: rtl/i2s_tx_tdm.sv
// i2s_tx_tdm: NUM_CH-slot serial audio transmitter (I2S / left-justified / TDM)
// with a one-deep frame holding buffer and underrun signalling.
module i2s_tx_tdm import i2s_pkg::*; #(
    parameter int   SAMPLE_W = 16,
    parameter int   SLOT_W   = 16,
    parameter int   NUM_CH   = 2,
    parameter fmt_e FMT      = FMT_I2S
) (
    input  logic          sclk,
    input  logic          rst,
    i2s_tx_tdm_if.slave   s,
    output logic          ws,
    output logic          sdata,
    output logic          frame_start,
    output logic          underrun
);
    localparam int F  = frame_len(NUM_CH, SLOT_W);
    localparam int HW = NUM_CH * SAMPLE_W;
    if (!params_ok(SAMPLE_W, SLOT_W, NUM_CH)) begin : g_bad_params
        $fatal(1, "i2s_tx_tdm: illegal SAMPLE_W/SLOT_W/NUM_CH combination");
    end
    logic [HW-1:0] hold;
    logic [F-1:0]  sr, padded, nxt_frame;
    logic          full, last, accept;
    i2s_frame_ctr #(.SLOT_W(SLOT_W), .NUM_CH(NUM_CH)) u_ctr (
        .sclk (sclk),
        .rst  (rst),
        .ws   (ws),
        .last (last)
    );
    assign s.ready = ~full;
    assign accept  = s.valid & ~full;
    for (genvar c = 0; c < NUM_CH; c++) begin : g_pad
        assign padded[(NUM_CH-c)*SLOT_W-1 -: SLOT_W] =
            SLOT_W'(hold[(NUM_CH-c)*SAMPLE_W-1 -: SAMPLE_W]) << (SLOT_W - SAMPLE_W);
    end
    assign nxt_frame = full ? padded : '0;
    // sr holds the current frame shifted so sr[F-1] is the bit presented at this pos;
    // LJ looks one bit ahead, I2S emits the bit of the previous pos.
    always_ff @(posedge sclk or posedge rst)
        if (rst) begin
            hold        <= '0;
            full        <= 1'b0;
            sr          <= '0;
            sdata       <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            hold        <= accept ? s.data : hold;
            full        <= accept | (full & ~last);
            sr          <= last ? nxt_frame : sr << 1;
            sdata       <= FMT == FMT_LJ ? (last ? nxt_frame[F-1] : sr[F-2]) : sr[F-1];
            frame_start <= last;
            underrun    <= last & ~full;
        end
endmodule

// File: tb/tb_i2s_tx_tdm.sv
// tb_i2s_tx_tdm: directed checks of stereo I2S, LJ with slot padding and 4-slot TDM.
module tb_i2s_tx_tdm;
    import i2s_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    logic a_ws, a_sd, a_fs, a_ur;
    logic b_ws, b_sd, b_fs, b_ur;
    logic c_ws, c_sd, c_fs, c_ur;
    logic [63:0] v_sd, v_ws, v_fs, v_ur, v_rd;
    logic [63:0] tmp;

    always #5 clk = ~clk;

    i2s_tx_tdm_if #(.W(32)) a_if ();
    i2s_tx_tdm_if #(.W(48)) b_if ();
    i2s_tx_tdm_if #(.W(64)) c_if ();

    i2s_tx_tdm u_a (.sclk(clk), .rst(rst), .s(a_if), .ws(a_ws), .sdata(a_sd), .frame_start(a_fs), .underrun(a_ur));
    i2s_tx_tdm #(.SAMPLE_W(24), .SLOT_W(32), .NUM_CH(2), .FMT(FMT_LJ)) u_b (
        .sclk(clk), .rst(rst), .s(b_if), .ws(b_ws), .sdata(b_sd), .frame_start(b_fs), .underrun(b_ur));
    i2s_tx_tdm #(.SAMPLE_W(16), .SLOT_W(16), .NUM_CH(4), .FMT(FMT_I2S)) u_c (
        .sclk(clk), .rst(rst), .s(c_if), .ws(c_ws), .sdata(c_sd), .frame_start(c_fs), .underrun(c_ur));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // I2S stream over a frame: previous frame's last bit, then the frame minus its LSB
    function automatic logic [63:0] i2s_exp(input int f, input logic p, input logic [63:0] frm);
        return f == 32 ? {32'h0, p, frm[31:1]} : {p, frm[63:1]};
    endfunction

    task automatic drive(input int d, input logic v, input logic [63:0] od);
        if (d == 0) begin
            a_if.valid = v;
            a_if.data  = od[31:0];
        end else if (d == 1) begin
            b_if.valid = v;
            b_if.data  = od[47:0];
        end else begin
            c_if.valid = v;
            c_if.data  = od;
        end
    endtask

    // Steps n edges (the first is expected to be a frame boundary) and records outputs MSB-first.
    task automatic cap(input int d, input int n, input int off, input logic [63:0] od);
        v_sd = '0; v_ws = '0; v_fs = '0; v_ur = '0; v_rd = '0;
        for (int i = 0; i < n; i++) begin
            if (i == off) drive(d, 1'b1, od);
            @(posedge clk);
            #1;
            v_sd = {v_sd[62:0], d == 0 ? a_sd : d == 1 ? b_sd : c_sd};
            v_ws = {v_ws[62:0], d == 0 ? a_ws : d == 1 ? b_ws : c_ws};
            v_fs = {v_fs[62:0], d == 0 ? a_fs : d == 1 ? b_fs : c_fs};
            v_ur = {v_ur[62:0], d == 0 ? a_ur : d == 1 ? b_ur : c_ur};
            v_rd = {v_rd[62:0], d == 0 ? a_if.ready : d == 1 ? b_if.ready : c_if.ready};
            if (i == off) drive(d, 1'b0, '0);
        end
    endtask

    task automatic rchk(input int d);
        chk($sformatf("rst_ws%0d", d), 64'(d == 0 ? a_ws : d == 1 ? b_ws : c_ws), 64'd1);
        chk($sformatf("rst_sd%0d", d), 64'(d == 0 ? a_sd : d == 1 ? b_sd : c_sd), 64'd0);
        chk($sformatf("rst_rdy%0d", d), 64'(d == 0 ? a_if.ready : d == 1 ? b_if.ready : c_if.ready), 64'd1);
        chk($sformatf("rst_fs%0d", d), 64'(d == 0 ? a_fs : d == 1 ? b_fs : c_fs), 64'd0);
        chk($sformatf("rst_ur%0d", d), 64'(d == 0 ? a_ur : d == 1 ? b_ur : c_ur), 64'd0);
    endtask

    initial begin
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        drive(2, 1'b0, '0);
        repeat (2) @(negedge clk);
        rchk(0);
        rchk(1);
        rchk(2);
        @(negedge clk) rst = 1'b0;
        // stereo I2S: first frame after reset underruns, word offered on that boundary plays next
        cap(0, 32, 0, 64'hA55A3C12);
        chk("a0_sd", v_sd, 64'h0);
        chk("a0_ws", v_ws, 64'h0000FFFF);
        chk("a0_fs", v_fs, 64'h80000000);
        chk("a0_ur", v_ur, 64'h80000000);
        chk("a0_rdy", v_rd, 64'h0);
        cap(0, 32, 5, 64'h1234F00D);
        chk("a1_sd", v_sd, i2s_exp(32, 1'b0, 64'hA55A3C12));
        chk("a1_ws", v_ws, 64'h0000FFFF);
        chk("a1_fs", v_fs, 64'h80000000);
        chk("a1_ur", v_ur, 64'h0);
        chk("a1_rdy", v_rd, 64'hF8000000);
        cap(0, 32, -1, '0);
        chk("a2_sd", v_sd, i2s_exp(32, 1'b0, 64'h1234F00D));
        chk("a2_ur", v_ur, 64'h0);
        chk("a2_rdy", v_rd, 64'hFFFFFFFF);
        cap(0, 32, -1, '0);
        chk("a3_sd", v_sd, i2s_exp(32, 1'b1, 64'h0));
        chk("a3_ur", v_ur, 64'h80000000);
        chk("a3_fs", v_fs, 64'h80000000);
        cap(0, 32, 0, 64'hCAFE0BEE);
        chk("a4_sd", v_sd, 64'h0);
        chk("a4_ur", v_ur, 64'h80000000);
        chk("a4_rdy", v_rd, 64'h0);
        cap(0, 32, 3, 64'hA5A55A5A);
        chk("a5_sd", v_sd, i2s_exp(32, 1'b0, 64'hCAFE0BEE));
        chk("a5_ur", v_ur, 64'h0);
        chk("a5_rdy", v_rd, 64'hE0000000);
        // reset asserted mid-frame with a further word pending in the holding buffer
        cap(0, 10, 2, 64'h11112222);
        tmp = i2s_exp(32, 1'b0, 64'hA5A55A5A) >> 22;
        chk("a6_sd", v_sd, tmp);
        chk("a6_rdy", v_rd, 64'h300);
        chk("a6_fs", v_fs, 64'h200);
        rst = 1'b1;
        #1;
        rchk(0);
        @(negedge clk) rst = 1'b0;
        cap(0, 32, -1, '0);
        chk("a7_sd", v_sd, 64'h0);
        chk("a7_ur", v_ur, 64'h80000000);
        chk("a7_fs", v_fs, 64'h80000000);
        chk("a7_rdy", v_rd, 64'hFFFFFFFF);
        // left-justified, 24-bit samples in 32-bit slots
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        cap(1, 64, 0, 64'h0000ABCDEF123456);
        chk("b0_sd", v_sd, 64'h0);
        chk("b0_ur", v_ur, 64'h8000000000000000);
        cap(1, 64, -1, '0);
        chk("b1_sd", v_sd, 64'hABCDEF0012345600);
        chk("b1_ws", v_ws, 64'h00000000FFFFFFFF);
        chk("b1_fs", v_fs, 64'h8000000000000000);
        chk("b1_ur", v_ur, 64'h0);
        // 4-slot TDM, I2S delay
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        cap(2, 64, 0, 64'h00018000FFFF0000);
        chk("c0_ur", v_ur, 64'h8000000000000000);
        cap(2, 64, -1, '0);
        chk("c1_sd", v_sd, 64'h0000C0007FFF8000);
        chk("c1_ws", v_ws, 64'h00000000FFFFFFFF);
        chk("c1_fs", v_fs, 64'h8000000000000000);
        chk("c1_ur", v_ur, 64'h0);
        chk("c1_rdy", v_rd, 64'hFFFFFFFFFFFFFFFF);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
